// File: rtl/jtag_debug_sysclk_bridge.sv
// jtag_debug_sysclk_bridge: moves JTAG update-IR/update-DR events from the tck
// domain into clk. It captures the instruction and the scan word, and it raises
// one action or no-action strobe on the channel selected by the instruction.
module jtag_debug_sysclk_bridge #(
    parameter int DATA_W      = 38,
    parameter int IR_W        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int HANDSHAKE   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 vs_uir,
    input  logic                 vs_udr,
    input  logic [IR_W-1:0]      ir_in,
    input  logic [DATA_W-1:0]    sr,
    input  logic                 cmd_ready,
    input  logic                 overrun_clr,
    output logic [DATA_W-1:0]    jdo,
    output logic [IR_W-1:0]      ir_q,
    output logic [(2**IR_W)-1:0] take_action,
    output logic [(2**IR_W)-1:0] take_no_action,
    output logic                 overrun
);
    localparam int NCH = 2**IR_W;
    localparam int S   = SYNC_STAGES;
    localparam bit HS  = (HANDSHAKE != 0);

    logic [S-1:0]      uir_sync_q, uir_sync_d, udr_sync_q, udr_sync_d;
    logic [S-1:0]      vld_pipe_q, vld_pipe_d;
    logic              uir_dly_q, uir_dly_d, udr_dly_q, udr_dly_d;
    logic              uir_arm_q, uir_arm_d, udr_arm_q, udr_arm_d;
    logic [DATA_W-1:0] jdo_q, jdo_d;
    logic [IR_W-1:0]   ir_reg_q, ir_reg_d;
    logic [NCH-1:0]    act_q, act_d, nact_q, nact_d;
    logic              ovr_q, ovr_d;

    logic              uir_rise, udr_rise, pending, accept, drop;
    logic [NCH-1:0]    ch_onehot;

    // Rising-edge detection. vld_pipe marks which synchroniser stages hold real
    // samples, not reset zeros. A channel is armed only after a real low
    // reaches its last stage, so a level that is still high after reset
    // produces no edge.
    assign uir_rise  = uir_sync_q[S-1] & ~uir_dly_q & uir_arm_q;
    assign udr_rise  = udr_sync_q[S-1] & ~udr_dly_q & udr_arm_q;
    assign pending   = |(act_q | nact_q);
    assign ch_onehot = {{(NCH-1){1'b0}}, 1'b1} << ir_reg_q;

    // Next-state logic for synchronisers, capture registers, strobes and overrun
    always_comb begin
        vld_pipe_d = {vld_pipe_q[S-2:0], 1'b1};
        uir_sync_d = {uir_sync_q[S-2:0], vs_uir};
        udr_sync_d = {udr_sync_q[S-2:0], vs_udr};
        uir_dly_d  = uir_sync_q[S-1];
        udr_dly_d  = udr_sync_q[S-1];
        uir_arm_d  = uir_arm_q | (vld_pipe_q[S-1] & ~uir_sync_q[S-1]);
        udr_arm_d  = udr_arm_q | (vld_pipe_q[S-1] & ~udr_sync_q[S-1]);

        jdo_d    = jdo_q;
        ir_reg_d = uir_rise ? ir_in : ir_reg_q;

        // Pulse mode clears the strobes every cycle. Handshake mode holds them until cmd_ready.
        act_d  = (HS && !cmd_ready) ? act_q  : '0;
        nact_d = (HS && !cmd_ready) ? nact_q : '0;

        // A new command is rejected only if the previous one is still held and not acknowledged.
        accept = udr_rise & (~HS | ~pending | cmd_ready);
        drop   = udr_rise & ~accept;

        // Decode uses ir_reg_q, the instruction held before this edge, so a
        // same-cycle IR update does not steer the command.
        if (accept) begin
            jdo_d = sr;
            if (sr[DATA_W-1]) begin
                act_d  = ch_onehot;
                nact_d = '0;
            end else begin
                act_d  = '0;
                nact_d = ch_onehot;
            end
        end

        // A set on a dropped command wins over a clear in the same cycle.
        if (drop)             ovr_d = 1'b1;
        else if (overrun_clr) ovr_d = 1'b0;
        else                  ovr_d = ovr_q;
    end

    // State registers with asynchronous active-high reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe_q <= '0;
            uir_sync_q <= '0;
            udr_sync_q <= '0;
            uir_dly_q  <= 1'b0;
            udr_dly_q  <= 1'b0;
            uir_arm_q  <= 1'b0;
            udr_arm_q  <= 1'b0;
            jdo_q      <= '0;
            ir_reg_q   <= '0;
            act_q      <= '0;
            nact_q     <= '0;
            ovr_q      <= 1'b0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            uir_sync_q <= uir_sync_d;
            udr_sync_q <= udr_sync_d;
            uir_dly_q  <= uir_dly_d;
            udr_dly_q  <= udr_dly_d;
            uir_arm_q  <= uir_arm_d;
            udr_arm_q  <= udr_arm_d;
            jdo_q      <= jdo_d;
            ir_reg_q   <= ir_reg_d;
            act_q      <= act_d;
            nact_q     <= nact_d;
            ovr_q      <= ovr_d;
        end
    end

    assign jdo            = jdo_q;
    assign ir_q           = ir_reg_q;
    assign take_action    = act_q;
    assign take_no_action = nact_q;
    assign overrun        = ovr_q;

endmodule

// File: tb/tb_jtag_debug_sysclk_bridge.sv
// Testbench for jtag_debug_sysclk_bridge. It drives three configurations:
// pulse mode, handshake mode, and 3-stage synchroniser with an 8-channel IR.
// Expected commands go into a scoreboard queue and are compared when a strobe appears.
module tb_jtag_debug_sysclk_bridge;
    logic        clk, reset, vs_uir, vs_udr, cmd_ready, overrun_clr;
    logic [1:0]  ir2;
    logic [2:0]  ir3;
    logic [37:0] sr;

    logic [37:0] jdo0, jdo1, jdo2;
    logic [1:0]  irq0, irq1;
    logic [2:0]  irq2;
    logic [3:0]  ta0, tn0, ta1, tn1;
    logic [7:0]  ta2, tn2;
    logic        ov0, ov1, ov2;

    jtag_debug_sysclk_bridge dut0 (
        .clk(clk), .reset(reset), .vs_uir(vs_uir), .vs_udr(vs_udr), .ir_in(ir2), .sr(sr),
        .cmd_ready(cmd_ready), .overrun_clr(overrun_clr), .jdo(jdo0), .ir_q(irq0),
        .take_action(ta0), .take_no_action(tn0), .overrun(ov0));

    jtag_debug_sysclk_bridge #(.HANDSHAKE(1)) dut1 (
        .clk(clk), .reset(reset), .vs_uir(vs_uir), .vs_udr(vs_udr), .ir_in(ir2), .sr(sr),
        .cmd_ready(cmd_ready), .overrun_clr(overrun_clr), .jdo(jdo1), .ir_q(irq1),
        .take_action(ta1), .take_no_action(tn1), .overrun(ov1));

    jtag_debug_sysclk_bridge #(.SYNC_STAGES(3), .IR_W(3)) dut2 (
        .clk(clk), .reset(reset), .vs_uir(vs_uir), .vs_udr(vs_udr), .ir_in(ir3), .sr(sr),
        .cmd_ready(cmd_ready), .overrun_clr(overrun_clr), .jdo(jdo2), .ir_q(irq2),
        .take_action(ta2), .take_no_action(tn2), .overrun(ov2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          sel;
        logic [37:0] jdo;
        logic [7:0]  ta;
        logic [7:0]  tn;
        int          lat;
    } exp_t;
    exp_t sbq[$];

    int          sel;
    int          npass, ntot;
    logic [37:0] s_jdo;
    logic [7:0]  s_ta, s_tn;

    // Route the selected DUT's outputs onto one common view
    always_comb begin
        s_jdo = jdo0;
        s_ta  = {4'b0, ta0};
        s_tn  = {4'b0, tn0};
        case (sel)
            1: begin s_jdo = jdo1; s_ta = {4'b0, ta1}; s_tn = {4'b0, tn1}; end
            2: begin s_jdo = jdo2; s_ta = ta2; s_tn = tn2; end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntot++;
        assert (obs === exp) begin
            npass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(6);
    endtask

    task automatic issue_ir(input logic [2:0] v);
        ir2    = v[1:0];
        ir3    = v;
        vs_uir = 1'b1;
        tick(6);
        vs_uir = 1'b0;
        tick(6);
    endtask

    // Wait (bounded) for a strobe on the selected DUT, then pop and compare the scoreboard entry
    task automatic wait_strobe();
        int   cnt;
        exp_t e;
        cnt = 0;
        while ((s_ta | s_tn) == 8'h00 && cnt < 20) begin
            tick(1);
            cnt++;
        end
        if (sbq.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sbq.pop_front();
            chk("sb_sel", 64'(sel), 64'(e.sel));
            chk("latency", 64'(cnt), 64'(e.lat));
            chk("jdo", 64'(s_jdo), 64'(e.jdo));
            chk("take_action", 64'(s_ta), 64'(e.ta));
            chk("take_no_action", 64'(s_tn), 64'(e.tn));
        end
    endtask

    task automatic send_cmd(input logic [37:0] d, input logic [7:0] ta, input logic [7:0] tn,
                            input int lat);
        int cnt;
        sr     = d;
        vs_udr = 1'b1;
        sbq.push_back('{sel, d, ta, tn, lat});
        wait_strobe();
        if (sel != 1) begin
            tick(1);
            chk("pulse_end", 64'(s_ta | s_tn), 64'd0);
            cnt = 0;
            for (int i = 0; i < 8; i++) begin
                tick(1);
                if ((s_ta | s_tn) != 8'h00) cnt++;
            end
            chk("no_retrigger", 64'(cnt), 64'd0);
        end else begin
            tick(8);
        end
        vs_udr = 1'b0;
        tick(6);
    endtask

    initial begin
        int cnt;
        npass = 0; ntot = 0; sel = 0;
        reset = 1'b1; vs_uir = 1'b0; vs_udr = 1'b0; cmd_ready = 1'b0; overrun_clr = 1'b0;
        ir2 = '0; ir3 = '0; sr = '0;
        tick(2);
        chk("rst_jdo0", 64'(jdo0), 64'd0);
        chk("rst_irq0", 64'(irq0), 64'd0);
        chk("rst_strb", 64'({ta0, tn0, ta1, tn1, ta2, tn2}), 64'd0);
        chk("rst_ovr", 64'({ov0, ov1, ov2}), 64'd0);
        reset = 1'b0;
        tick(6);

        // Pulse mode: action on channel 1, no-action on channel 3
        issue_ir(3'd1);
        chk("irq0_1", 64'(irq0), 64'd1);
        send_cmd(38'h20_0000_1234, 8'b0000_0010, 8'h00, 3);
        issue_ir(3'd3);
        send_cmd(38'h00_0000_00AB, 8'h00, 8'b0000_1000, 3);

        // Coincident IR and DR edges: the command decodes with the old IR (3)
        ir2 = 2'd2; ir3 = 3'd2; sr = 38'h21_0000_5678;
        vs_uir = 1'b1; vs_udr = 1'b1;
        sbq.push_back('{0, 38'h21_0000_5678, 8'b0000_1000, 8'h00, 3});
        wait_strobe();
        chk("irq0_coinc", 64'(irq0), 64'd2);
        tick(1);
        vs_uir = 1'b0; vs_udr = 1'b0;
        tick(6);

        // Handshake mode: strobe held until cmd_ready
        sel = 1;
        do_reset();
        issue_ir(3'd0);
        send_cmd(38'h20_0000_00C1, 8'h01, 8'h00, 3);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (ta1[0]) cnt++;
        end
        chk("hs_hold", 64'(cnt), 64'd10);
        cmd_ready = 1'b1;
        tick(1);
        chk("hs_clear", 64'(ta1), 64'd0);
        cmd_ready = 1'b0;
        tick(2);

        // Overrun: a second command while one is pending is dropped
        send_cmd(38'h20_0000_0A01, 8'h01, 8'h00, 3);
        sr = 38'h20_0000_0B02; vs_udr = 1'b1;
        tick(3);
        chk("ovr_set", 64'(ov1), 64'd1);
        chk("ovr_jdo_kept", 64'(jdo1), 64'(38'h20_0000_0A01));
        chk("ovr_strb_kept", 64'(ta1), 64'd1);
        vs_udr = 1'b0;
        tick(6);
        overrun_clr = 1'b1;
        tick(1);
        chk("ovr_clr", 64'(ov1), 64'd0);
        sr = 38'h20_0000_0B03; vs_udr = 1'b1;
        tick(3);
        chk("ovr_set_wins", 64'(ov1), 64'd1);
        overrun_clr = 1'b0;
        tick(1);
        chk("ovr_sticky", 64'(ov1), 64'd1);
        vs_udr = 1'b0;
        tick(6);

        // New edge together with cmd_ready: old command retires, new one is taken
        sr = 38'h00_0000_0C04; vs_udr = 1'b1;
        tick(2);
        cmd_ready = 1'b1;
        tick(1);
        chk("retire_jdo", 64'(jdo1), 64'(38'h00_0000_0C04));
        chk("retire_ta", 64'(ta1), 64'd0);
        chk("retire_tn", 64'(tn1), 64'd1);
        cmd_ready = 1'b0;
        tick(1);
        chk("retire_tn_held", 64'(tn1), 64'd1);
        vs_udr = 1'b0;
        tick(6);

        // Reset one cycle after a DR rise, with the level still high through release
        sel = 0;
        do_reset();
        issue_ir(3'd1);
        send_cmd(38'h20_0000_0F0F, 8'b0000_0010, 8'h00, 3);
        sr = 38'h20_0000_1111; vs_udr = 1'b1;
        tick(1);
        reset = 1'b1;
        #1;
        chk("mid_rst_jdo", 64'(jdo0), 64'd0);
        chk("mid_rst_irq", 64'(irq0), 64'd0);
        chk("mid_rst_strb", 64'({ta0, tn0}), 64'd0);
        tick(2);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if ((ta0 | tn0) != 4'h0) cnt++;
        end
        chk("mid_rst_no_strobe", 64'(cnt), 64'd0);
        chk("mid_rst_jdo_after", 64'(jdo0), 64'd0);
        vs_udr = 1'b0;
        tick(6);
        send_cmd(38'h20_0000_0D0D, 8'h01, 8'h00, 3);

        // Three synchroniser stages, eight channels
        sel = 2;
        do_reset();
        issue_ir(3'd5);
        chk("irq2_5", 64'(irq2), 64'd5);
        send_cmd(38'h20_0000_0E0E, 8'b0010_0000, 8'h00, 4);

        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
